// File: rtl/data_cache_pkg.sv
// Shared types for the direct-mapped write-back data cache: FSM state,
// default geometry and address-field helpers.
package cache_types;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } cache_state_t;

  localparam int IDX_W  = 3;
  localparam int OFF_W  = 5;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int LINE_W = 256;

  // Extract a w-bit field starting at bit lo; caller casts to the field width.
  function automatic logic [31:0] addr_field(input logic [31:0] a, input int lo, input int w);
    return (a >> lo) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a, input int off);
    return a & ~((32'd1 << off) - 32'd1);
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Line store: one line per set, byte-enable write, asynchronous read, no reset.
module data_cache_array #(
  parameter int S_INDEX = 3,
  parameter int LINE_W  = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [S_INDEX-1:0]    index,
  input  logic [LINE_W/8-1:0]   wmask,
  input  logic [LINE_W-1:0]     wdata,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] mem [2**S_INDEX];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < LINE_W/8; b++) begin
        if (wmask[b]) mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete in the
// request cycle; misses write back a dirty victim, then fill the line.
module data_cache
  import cache_types::*;
#(
  parameter int S_INDEX  = IDX_W,
  parameter int S_OFFSET = OFF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  data_addr,
  input  logic         data_read,
  input  logic         data_write,
  input  logic [3:0]   data_mbe,
  input  logic [31:0]  data_wdata,
  output logic [31:0]  data_rdata,
  output logic         data_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int TW    = 32 - S_INDEX - S_OFFSET;
  localparam int LW    = 8 << S_OFFSET;
  localparam int WORDS = LW / 32;
  localparam int SETS  = 2 ** S_INDEX;

  cache_state_t state, next;

  logic [SETS-1:0]     valid, dirty;
  logic [TW-1:0]       tags [SETS];

  logic [S_INDEX-1:0]  idx;
  logic [TW-1:0]       tag;
  logic [S_OFFSET-3:0] word;
  logic                req, hit;

  logic                arr_we;
  logic [LW/8-1:0]     arr_wmask;
  logic [LW-1:0]       arr_wdata, line;
  logic                set_dirty, fill_done;

  assign idx  = S_INDEX'(addr_field(data_addr, S_OFFSET, S_INDEX));
  assign tag  = TW'(addr_field(data_addr, S_INDEX + S_OFFSET, TW));
  assign word = (S_OFFSET-2)'(addr_field(data_addr, 2, S_OFFSET - 2));
  assign req  = data_read | data_write;
  assign hit  = valid[idx] && (tags[idx] == tag);

  data_cache_array #(.S_INDEX(S_INDEX), .LINE_W(LW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .index (idx),
    .wmask (arr_wmask),
    .wdata (arr_wdata),
    .rdata (line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= next;
      if (set_dirty) dirty[idx] <= 1'b1;
      if (fill_done) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // Tags sit behind valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (fill_done) tags[idx] <= tag;
  end

  always_comb begin
    next         = state;
    data_resp    = 1'b0;
    data_rdata   = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    arr_we       = 1'b0;
    arr_wmask    = '0;
    arr_wdata    = pmem_rdata;
    set_dirty    = 1'b0;
    fill_done    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            data_resp = 1'b1;
            // Write wins when read and write are both asserted.
            if (data_write) begin
              arr_we    = 1'b1;
              arr_wmask = (LW/8)'(data_mbe) << {word, 2'b00};
              arr_wdata = {WORDS{data_wdata}};
              set_dirty = 1'b1;
            end else begin
              data_rdata = line[word*32 +: 32];
            end
          end else if (valid[idx] && dirty[idx]) begin
            next = WRITEBACK;
          end else begin
            next = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tags[idx], idx, {S_OFFSET{1'b0}}};
        pmem_wdata   = line;
        if (pmem_resp) next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = line_base(data_addr, S_OFFSET);
        if (pmem_resp) begin
          arr_we    = 1'b1;
          arr_wmask = '1;
          arr_wdata = pmem_rdata;
          fill_done = 1'b1;
          next      = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Random and directed requests against a flat word-memory reference plus a
// per-set residency model that predicts hits, writebacks and fills.
module tb_data_cache;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  data_addr = '0;
  logic         data_read = 1'b0, data_write = 1'b0;
  logic [3:0]   data_mbe = '0;
  logic [31:0]  data_wdata = '0;
  logic [31:0]  data_rdata;
  logic         data_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .data_read(data_read),
    .data_write(data_write), .data_mbe(data_mbe), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_resp(data_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Architectural word memory and the backing line memory.
  logic [31:0]  refm [logic [31:0]];
  logic [255:0] bmem [logic [31:0]];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [31:0]  m_line  [8];

  logic        hold_resp = 1'b0;
  int          wait_cnt = 0;
  int          nstrobe = 0, nwb = 0, nfill = 0;
  logic [31:0] exp_wb_addr = '0, exp_fill_addr = '0;
  logic [31:0] last_rdata;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (refm.exists(a)) return refm[a];
    return init_word(a);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = ref_word(la + 32'(w*4));
    return r;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] r;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = init_word(la + 32'(w*4));
    return r;
  endfunction

  task automatic preset_word(input logic [31:0] a, input logic [31:0] v);
    logic [31:0]  la;
    logic [255:0] l;
    la = {a[31:5], 5'b0};
    l = mem_line(la);
    l[a[4:2]*32 +: 32] = v;
    bmem[la] = l;
    refm[a] = v;
  endtask

  // Reset throws away dirty lines, so the architectural view reverts to memory.
  task automatic model_reset();
    logic [255:0] l;
    for (int s = 0; s < 8; s++) begin
      if (m_valid[s] && m_dirty[s]) begin
        l = mem_line(m_line[s]);
        for (int w = 0; w < 8; w++) refm[m_line[s] + 32'(w*4)] = l[w*32 +: 32];
      end
      m_valid[s] = 0;
      m_dirty[s] = 0;
    end
  endtask

  // Physical-memory responder with 0..2 extra wait cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (pmem_resp) pmem_resp = 1'b0;
      if (!rst && (pmem_read || pmem_write)) begin
        nstrobe++;
        chk("pmem_excl", 256'(pmem_read & pmem_write), 256'd0);
        if (pmem_write) chk("wb_addr", pmem_address, exp_wb_addr);
        else            chk("fill_addr", pmem_address, exp_fill_addr);
        if (!hold_resp) begin
          if (wait_cnt == 0) begin
            if (pmem_write) begin
              chk("wb_data", pmem_wdata, ref_line(pmem_address));
              bmem[pmem_address] = pmem_wdata;
              nwb++;
            end else begin
              pmem_rdata = mem_line(pmem_address);
              nfill++;
            end
            pmem_resp = 1'b1;
            wait_cnt = $urandom_range(0, 2);
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] a0, input logic rd, input logic wr,
                        input logic [3:0] mbe, input logic [31:0] wd);
    logic [31:0] a, la, v;
    int s, cyc;
    bit hit, ewb;
    a   = {a0[31:2], 2'b00};
    la  = {a[31:5], 5'b0};
    s   = int'(a[7:5]);
    hit = m_valid[s] && (m_line[s] == la);
    ewb = !hit && m_valid[s] && m_dirty[s];
    exp_wb_addr = m_line[s];
    exp_fill_addr = la;
    nstrobe = 0; nwb = 0; nfill = 0;
    @(posedge clk); #1;
    data_addr = a0; data_read = rd; data_write = wr; data_mbe = mbe; data_wdata = wd;
    cyc = 0;
    for (;;) begin
      @(negedge clk);
      if (data_resp) break;
      cyc++;
      if (cyc > 80) begin
        chk("resp_timeout", 256'(cyc), 256'd0);
        break;
      end
    end
    last_rdata = data_rdata;
    if (hit) chk("hit_lat", 256'(cyc), 256'd0);
    else     chk("miss_lat", 256'(cyc), 256'(1 + nstrobe));
    chk("wb_cnt", 256'(nwb), 256'(ewb));
    chk("fill_cnt", 256'(nfill), hit ? 256'd0 : 256'd1);
    if (!wr) chk("rdata", last_rdata, ref_word(a));
    if (wr) begin
      v = ref_word(a);
      for (int k = 0; k < 4; k++) if (mbe[k]) v[k*8 +: 8] = wd[k*8 +: 8];
      refm[a] = v;
    end
    m_dirty[s] = wr ? 1'b1 : (hit ? m_dirty[s] : 1'b0);
    m_valid[s] = 1'b1;
    m_line[s]  = la;
  endtask

  initial begin
    logic [255:0] t;
    logic [31:0]  ra;
    int op;
    repeat (2) @(negedge clk);
    chk("rst_resp", 256'(data_resp), 256'd0);
    chk("rst_pread", 256'(pmem_read), 256'd0);
    chk("rst_pwrite", 256'(pmem_write), 256'd0);
    chk("rst_paddr", 256'(pmem_address), 256'd0);
    chk("rst_pwdata", pmem_wdata, 256'd0);
    chk("rst_rdata", 256'(data_rdata), 256'd0);
    @(posedge clk); #1 rst = 1'b0;

    preset_word(32'h40, 32'hDEADBEEF);
    preset_word(32'h44, 32'hAABBCCDD);
    do_req(32'h40, 1, 0, 4'h0, 32'h0);
    chk("tp_first_read", 256'(last_rdata), 256'(32'hDEADBEEF));
    do_req(32'h40, 1, 0, 4'h0, 32'h0);
    do_req(32'h44, 0, 1, 4'b0011, 32'h12345678);
    do_req(32'h44, 1, 0, 4'h0, 32'h0);
    chk("tp_merge", 256'(last_rdata), 256'(32'hAABB5678));
    do_req(32'h140, 1, 0, 4'h0, 32'h0);
    t = bmem[32'h40];
    chk("tp_wb_word", 256'(t[63:32]), 256'(32'hAABB5678));

    // Reset while a fill is outstanding.
    hold_resp = 1'b1;
    exp_fill_addr = 32'h40;
    @(posedge clk); #1;
    data_addr = 32'h40; data_read = 1'b1; data_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_fill", 256'(pmem_read), 256'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_pread", 256'(pmem_read), 256'd0);
    chk("rst_async_pwrite", 256'(pmem_write), 256'd0);
    chk("rst_async_resp", 256'(data_resp), 256'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; data_read = 1'b0;
    hold_resp = 1'b0; wait_cnt = 0;
    do_req(32'h40, 1, 0, 4'h0, 32'h0);

    do_req(32'h48, 1, 1, 4'hF, 32'hC0FFEE11);
    do_req(32'h48, 1, 0, 4'h0, 32'h0);
    chk("both_as_write", 256'(last_rdata), 256'(32'hC0FFEE11));

    for (int i = 0; i < 200; i++) begin
      ra = {22'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 3);
      do_req(ra, op != 2, op >= 2, 4'($urandom_range(0, 15)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache. It acts as the responder on the CPU data-memory interface: it accepts word requests from the memory-access stage and answers with `data_resp`/`data_rdata`. On a miss it becomes the initiator on a 256-bit line-wide physical-memory port. It sits between the pipeline's memory stage and the main-memory model or arbiter.

## Interface
Parameters:
- `S_INDEX`, 3: set-index bits, giving 8 sets.
- `S_OFFSET`, 5: line-offset bits, giving 32-byte lines. Tag width is 32 − `S_INDEX` − `S_OFFSET`.

Ports:
- Reset is asynchronous and active-high. There is one clock.
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous active-high reset.
- `data_addr`, in, 32: word address. Bits [1:0] are ignored.
- `data_read`, in, 1: read request.
- `data_write`, in, 1: write request.
- `data_mbe`, in, 4: byte enables for writes.
- `data_wdata`, in, 32: write data.
- `data_rdata`, out, 32: read word, valid when `data_resp`=1.
- `data_resp`, out, 1: one-cycle completion pulse.
- `pmem_address`, out, 32: line-aligned address.
- `pmem_read`, out, 1: line fill request.
- `pmem_write`, out, 1: line writeback request.
- `pmem_wdata`, out, 256: victim line.
- `pmem_rdata`, in, 256: fill line.
- `pmem_resp`, in, 1: physical-memory completion.

## Operation
- The requester holds `data_addr`, `data_read`, `data_write`, `data_mbe` and `data_wdata` stable until it sees `data_resp`.
- If `data_read` and `data_write` are both high, the request is handled as a write.
- Line state per set: `valid`, `dirty`, tag, and 256-bit data.
- `valid` and `dirty` are cleared by reset. Tag and data arrays are not reset.
- State machine, states IDLE, WRITEBACK, FILL:
  - IDLE, no request: outputs idle.
  - IDLE, hit (valid and tag match): assert `data_resp` combinationally in the same cycle.
    - Read: `data_rdata` = line word `data_addr[4:2]`.
    - Write: merge bytes selected by `data_mbe` into that word at the clock edge and set `dirty`.
    - Stay in IDLE.
  - IDLE, miss with dirty victim: go to WRITEBACK.
  - IDLE, miss with clean or invalid victim: go to FILL.
  - WRITEBACK:
    - `pmem_write`=1.
    - `pmem_address`={stored tag, index, 5'b0}.
    - `pmem_wdata`=victim line.
    - Hold until `pmem_resp`, then go to FILL.
  - FILL:
    - `pmem_read`=1.
    - `pmem_address`={`data_addr[31:5]`, 5'b0}.
    - On `pmem_resp`: write the line from `pmem_rdata`, load the tag, set `valid`=1 and `dirty`=0, then go to IDLE. The request then hits on the next cycle.
- Byte lane k of word w is line bits [w*32+k*8 +: 8].
- `pmem_read` and `pmem_write` are never high together.
- `pmem_address`, `pmem_wdata`, `pmem_read` and `pmem_write` are held stable until `pmem_resp`.

## Timing
- Reset values:
  - State = IDLE.
  - `data_resp`=0, `pmem_read`=0, `pmem_write`=0.
  - `data_rdata`=0 and `pmem_wdata`=0 while no response or writeback is in progress.
  - `pmem_address`=0.
- Hit: 0-cycle latency. `data_resp` is high in the cycle the request is presented, and the CPU stage does not stall.
- Clean miss: 1 cycle (IDLE detect) + fill cycles up to and including `pmem_resp` + 1 cycle hit.
- Dirty miss: writeback cycles are added before the fill.
- `data_resp` is high for exactly one cycle per request. The requester deasserts or changes its request on the following edge.
- A write hit and a read in the following cycle to the same word return the merged data.
- Reset asserted mid-WRITEBACK or mid-FILL:
  - The state machine returns to IDLE immediately.
  - The pmem strobes drop asynchronously.
  - All lines are invalidated, and dirty data is discarded.
- If `pmem_resp` arrives while the machine is in IDLE, it is ignored.

## Structure
- Shared package `cache_types`:
  - the state enum `cache_state_t` {IDLE, WRITEBACK, FILL};
  - the width constants for tag, index, offset and line (256);
  - the address-field extract helpers.
- One sub-module, `data_cache_array`: an `S_INDEX`-addressed line store with a 32-byte byte-enable write, asynchronous read, and no reset.
- Valid, dirty and tag bits are kept in flops in the top level, with the asynchronous clear.

## Test plan
- After reset, read 0x0000_0040: FILL with `pmem_address`=0x40. Return a line with word0=0xDEADBEEF. Exactly one `data_resp` follows, with `data_rdata`=0xDEADBEEF.
- Re-read 0x40: `data_resp` is in the same cycle and no pmem activity occurs.
- Write 0x44 with `data_mbe`=4'b0011 and wdata 0x12345678 over 0xAABBCCDD: `data_resp` is in the same cycle, and a read of 0x44 returns 0xAABB5678.
- Read 0x0000_0140 (same set, different tag): WRITEBACK to 0x40 with `pmem_wdata` containing 0xAABB5678 at bits [63:32], then FILL at 0x140, then `data_resp`.
- Assert `rst` during FILL: `pmem_read` falls without waiting for a clock, and the next read of 0x40 misses.
- Assert `data_read` and `data_write` together: the request behaves as a write, and `pmem_read`/`pmem_write` are never high together.
